// File: rtl/gray_to_bin_serial_pkg.sv
// Shared types for the serial Gray-to-binary decoder.
package gray_to_bin_serial_pkg;

    // Decoder FSM: waiting for a word, resolving bits, presenting the result.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } gray_dec_state_t;

endpackage

// File: rtl/gray_to_bin_serial.sv
// Serial Gray-to-binary decoder. Accepts one Gray word, resolves it MSB-first
// one bit per cycle (bin[i] = bin[i+1] ^ g[i], with bin[MSB] = g[MSB]) and
// presents the binary word on an output handshake.
//
// Handshakes: a transfer happens on a rising clk_i edge where valid and ready
// are both high. The source keeps gray_i/in_valid_i stable until in_ready_o;
// bin_o/out_valid_o are held stable until out_ready_i.
module gray_to_bin_serial
    import gray_to_bin_serial_pkg::*;
#(
    parameter int VEC_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [VEC_W-1:0] gray_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [VEC_W-1:0] bin_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [1:0]       state_o
);

    localparam int IDX_W = (VEC_W > 1) ? $clog2(VEC_W) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(VEC_W - 1);

    gray_dec_state_t  state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [VEC_W-1:0] gray_q, gray_d;
    logic [VEC_W-1:0] bin_q, bin_d;
    logic [VEC_W-1:0] bin_shr;

    // bin_shr[i] is the already-resolved bit above position i; the top
    // position sees a zero, so its result is simply the Gray bit.
    assign bin_shr = bin_q >> 1;

    // State, bit index and data registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            gray_q  <= '0;
            bin_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            gray_q  <= gray_d;
            bin_q   <= bin_d;
        end
    end

    // Next-state, bit resolution and handshake decode.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        gray_d      = gray_q;
        bin_d       = bin_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    gray_d  = gray_i;
                    bin_d   = '0;
                    idx_d   = IDX_TOP;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                for (int i = 0; i < VEC_W; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        bin_d[i] = bin_shr[i] ^ gray_q[i];
                    end
                end
                if (idx_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            ST_DONE: begin
                out_valid_o = 1'b1;
                // A new word may enter only in the cycle the result leaves.
                in_ready_o  = out_ready_i;
                if (out_ready_i) begin
                    if (in_valid_i) begin
                        gray_d  = gray_i;
                        bin_d   = '0;
                        idx_d   = IDX_TOP;
                        state_d = ST_CALC;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bin_o   = bin_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_gray_to_bin_serial.sv
// Directed bench for gray_to_bin_serial at widths 4, 8 and 1.
module tb_gray_to_bin_serial;

    logic clk;
    logic rst_n;

    logic [3:0] gray4, bin4;
    logic       iv4, ir4, ov4, or4;
    logic [1:0] st4;

    logic [7:0] gray8, bin8;
    logic       iv8, ir8, ov8, or8;
    logic [1:0] st8;

    logic [0:0] gray1, bin1;
    logic       iv1, ir1, ov1, or1;
    logic [1:0] st1;

    int checks = 0;
    int errors = 0;

    // Clock: 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    gray_to_bin_serial #(.VEC_W(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .gray_i(gray4), .in_valid_i(iv4),
        .in_ready_o(ir4), .bin_o(bin4), .out_valid_o(ov4),
        .out_ready_i(or4), .state_o(st4)
    );

    gray_to_bin_serial #(.VEC_W(8)) dut8 (
        .clk_i(clk), .rst_ni(rst_n), .gray_i(gray8), .in_valid_i(iv8),
        .in_ready_o(ir8), .bin_o(bin8), .out_valid_o(ov8),
        .out_ready_i(or8), .state_o(st8)
    );

    gray_to_bin_serial #(.VEC_W(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .gray_i(gray1), .in_valid_i(iv1),
        .in_ready_o(ir1), .bin_o(bin1), .out_valid_o(ov1),
        .out_ready_i(or1), .state_o(st1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One word through the 4-bit decoder with the consumer always ready.
    task automatic run4(input string tag, input logic [3:0] g, output logic [3:0] b);
        int edges;
        @(negedge clk);
        gray4 = g;
        iv4   = 1'b1;
        or4   = 1'b1;
        check({tag, " in_ready"}, 32'(ir4), 32'd1);
        @(negedge clk);
        iv4   = 1'b0;
        edges = 0;
        while (!ov4 && edges < 20) begin
            @(negedge clk);
            edges++;
        end
        check({tag, " latency"}, 32'(edges), 32'd4);
        check({tag, " out_valid"}, 32'(ov4), 32'd1);
        b = bin4;
        @(negedge clk);
        check({tag, " single"}, 32'(ov4), 32'd0);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] b;
        int edges;

        rst_n = 1'b0;
        gray4 = '0; iv4 = 1'b0; or4 = 1'b0;
        gray8 = '0; iv8 = 1'b0; or8 = 1'b0;
        gray1 = '0; iv1 = 1'b0; or1 = 1'b0;
        repeat (3) @(negedge clk);

        check("reset state", 32'(st4), 32'd0);
        check("reset out_valid", 32'(ov4), 32'd0);
        check("reset in_ready", 32'(ir4), 32'd1);
        check("reset bin", 32'(bin4), 32'd0);
        rst_n = 1'b1;

        // Basic decodes.
        run4("g0110", 4'b0110, b);
        check("g0110 bin", 32'(b), 32'b0100);
        run4("g1000", 4'b1000, b);
        check("g1000 bin", 32'(b), 32'b1111);
        run4("g0000", 4'b0000, b);
        check("g0000 bin", 32'(b), 32'b0000);

        // Backpressure: 1011 decodes to 1101.
        @(negedge clk);
        gray4 = 4'b1011; iv4 = 1'b1; or4 = 1'b0;
        @(negedge clk);
        iv4 = 1'b0;
        edges = 0;
        while (!ov4 && edges < 20) begin
            @(negedge clk);
            edges++;
        end
        check("bp latency", 32'(edges), 32'd4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp out_valid", 32'(ov4), 32'd1);
            check("bp bin", 32'(bin4), 32'b1101);
            check("bp in_ready", 32'(ir4), 32'd0);
        end
        or4 = 1'b1;
        @(negedge clk);
        check("bp release out_valid", 32'(ov4), 32'd0);
        check("bp release state", 32'(st4), 32'd0);

        // Back-to-back: 0001 -> 0001, then 0011 -> 0010.
        @(negedge clk);
        gray4 = 4'b0001; iv4 = 1'b1; or4 = 1'b1;
        @(negedge clk);
        gray4 = 4'b0011;
        check("b2b calc in_ready", 32'(ir4), 32'd0);
        edges = 0;
        while (!ov4 && edges < 20) begin
            @(negedge clk);
            edges++;
        end
        check("b2b first latency", 32'(edges), 32'd4);
        check("b2b first bin", 32'(bin4), 32'b0001);
        check("b2b done in_ready", 32'(ir4), 32'd1);
        @(negedge clk);
        iv4 = 1'b0;
        check("b2b second accepted", 32'(st4), 32'd1);
        check("b2b gap out_valid", 32'(ov4), 32'd0);
        edges = 0;
        while (!ov4 && edges < 20) begin
            @(negedge clk);
            edges++;
        end
        check("b2b second latency", 32'(edges), 32'd4);
        check("b2b second bin", 32'(bin4), 32'b0010);
        @(negedge clk);
        check("b2b no third", 32'(ov4), 32'd0);

        // Reset during the second CALC cycle.
        @(negedge clk);
        gray4 = 4'b0110; iv4 = 1'b1; or4 = 1'b1;
        @(negedge clk);
        iv4 = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("mid reset state", 32'(st4), 32'd0);
        check("mid reset out_valid", 32'(ov4), 32'd0);
        check("mid reset in_ready", 32'(ir4), 32'd1);
        check("mid reset bin", 32'(bin4), 32'd0);
        rst_n = 1'b1;
        run4("after reset", 4'b1111, b);
        check("after reset bin", 32'(b), 32'b1010);

        // Exhaustive 4-bit sweep: re-encoding the result must give the input.
        for (int g = 0; g < 16; g++) begin
            run4("sweep", 4'(g), b);
            check("sweep encode", 32'(b ^ (b >> 1)), 32'(g));
        end

        // 8-bit instance: FF decodes to AA in 8 cycles.
        @(negedge clk);
        gray8 = 8'hFF; iv8 = 1'b1; or8 = 1'b1;
        @(negedge clk);
        iv8 = 1'b0;
        edges = 0;
        while (!ov8 && edges < 30) begin
            @(negedge clk);
            edges++;
        end
        check("w8 latency", 32'(edges), 32'd8);
        check("w8 bin", 32'(bin8), 32'hAA);
        check("w8 state", 32'(st8), 32'd2);

        // 1-bit instance: one CALC cycle, bin equals gray.
        @(negedge clk);
        gray1 = 1'b1; iv1 = 1'b1; or1 = 1'b1;
        @(negedge clk);
        iv1 = 1'b0;
        edges = 0;
        while (!ov1 && edges < 10) begin
            @(negedge clk);
            edges++;
        end
        check("w1 latency", 32'(edges), 32'd1);
        check("w1 bin one", 32'(bin1), 32'd1);
        @(negedge clk);
        gray1 = 1'b0; iv1 = 1'b1;
        @(negedge clk);
        iv1 = 1'b0;
        edges = 0;
        while (!ov1 && edges < 10) begin
            @(negedge clk);
            edges++;
        end
        check("w1 zero latency", 32'(edges), 32'd1);
        check("w1 bin zero", 32'(bin1), 32'd0);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
